// File: rtl/counter_pkg.sv
// Shared constants and parameter legality check for the modulo-N up/down counter.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic bit params_legal(input int unsigned width,
                                      input int unsigned modulus,
                                      input int unsigned reset_val);
    return (width >= 2) && (width <= 16) &&
           (modulus >= 2) && (modulus <= (32'd1 << width)) &&
           (reset_val < modulus);
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and limit detection for one enabled step.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             en,
  output logic [WIDTH-1:0] next_count,
  output logic             limit_hit
);

  // Compare in WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] cnt_ext;
  logic           at_limit;

  always_comb begin
    cnt_ext    = {1'b0, count};
    at_limit   = (up_dn == DIR_UP) ? (cnt_ext == MAX_EXT) : (cnt_ext == '0);
    limit_hit  = en & at_limit;
    next_count = count;
    if (en) begin
      if (at_limit) begin
        if (sat_mode == MODE_WRAP)
          next_count = (up_dn == DIR_UP) ? '0 : MAX_W;
      end else if (up_dn == DIR_UP) begin
        next_count = WIDTH'(cnt_ext + 1'b1);
      end else begin
        next_count = WIDTH'(cnt_ext - 1'b1);
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous modulo-N up/down counter with load, saturate mode,
// terminal count, wrap pulse and sticky overflow flag.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 10,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);

  if (!params_legal(WIDTH, MODULUS, RESET_VAL)) begin : g_param_check
    $error("param_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_count;
  logic             limit_hit;
  logic [WIDTH-1:0] load_clamped;

  counter_next_calc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count_q),
    .up_dn      (up_dn),
    .sat_mode   (sat_mode),
    .en         (en),
    .next_count (step_count),
    .limit_hit  (limit_hit)
  );

  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_W;

  // Sticky flag: a limit event on the same edge as clr_ovf keeps it set.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = step_count;
      wrap_d  = limit_hit;
      if (limit_hit) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_W;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out  = count_q;
  assign wrap_pulse = wrap_q;
  assign ovf_sticky = ovf_q;
  assign tc = (up_dn == DIR_UP) ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed plus randomized check of param_updown_counter against an arithmetic reference model.
module tb_param_updown_counter;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;
  localparam int unsigned RV  = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b0, en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0;
  logic         load = 1'b0, clr_ovf = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count_out;
  logic         tc, wrap_pulse, ovf_sticky;

  int pass_cnt = 0;
  int total    = 0;

  int m_cnt  = 0;
  bit m_wrap = 0;
  bit m_ovf  = 0;

  param_updown_counter #(
    .WIDTH     (W),
    .MODULUS   (MOD),
    .RESET_VAL (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_dn      (up_dn),
    .sat_mode   (sat_mode),
    .load       (load),
    .load_val   (load_val),
    .clr_ovf    (clr_ovf),
    .count_out  (count_out),
    .tc         (tc),
    .wrap_pulse (wrap_pulse),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: apply one clock edge's worth of the counter's rules.
  task automatic model_edge(input bit r, input bit ld, input int lv, input bit e,
                            input bit ud, input bit sm, input bit clr);
    bit limit;
    if (r) begin
      m_cnt = RV; m_wrap = 0; m_ovf = 0;
    end else if (ld) begin
      m_cnt  = (lv < MOD) ? lv : MOD - 1;
      m_wrap = 0;
      m_ovf  = m_ovf && !clr;
    end else if (e) begin
      limit = ud ? (m_cnt == MOD - 1) : (m_cnt == 0);
      if (limit) begin
        if (!sm) m_cnt = ud ? 0 : MOD - 1;
        m_wrap = 1;
        m_ovf  = 1;
      end else begin
        m_cnt  = ud ? m_cnt + 1 : m_cnt - 1;
        m_wrap = 0;
        m_ovf  = m_ovf && !clr;
      end
    end else begin
      m_wrap = 0;
      m_ovf  = m_ovf && !clr;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit ld, input int lv,
                      input bit e, input bit ud, input bit sm, input bit clr);
    reset = r; load = ld; load_val = W'(lv); en = e; up_dn = ud;
    sat_mode = sm; clr_ovf = clr;
    @(posedge clk);
    model_edge(r, ld, lv, e, ud, sm, clr);
    #1;
    chk({tag, ".count"}, 32'(count_out), 32'(m_cnt));
    chk({tag, ".wrap"},  32'(wrap_pulse), 32'(m_wrap));
    chk({tag, ".ovf"},   32'(ovf_sticky), 32'(m_ovf));
    chk({tag, ".tc"},    32'(tc), 32'((up_dn ? (m_cnt == MOD - 1) : (m_cnt == 0))));
  endtask

  initial begin
    // 1: reset then count up through the 9->0 wrap
    step("rst0", 1, 0, 0, 0, 1, 0, 0);
    step("rst1", 1, 0, 0, 0, 1, 0, 0);
    chk("rst_count_zero", 32'(count_out), 32'd0);
    for (int i = 0; i < 12; i++) step("up", 0, 0, 0, 1, 1, 0, 0);
    chk("up_final_count", 32'(count_out), 32'd2);
    chk("up_ovf_after_wrap", 32'(ovf_sticky), 32'd1);

    // 2: down count in wrap mode from 2
    step("ld2", 0, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("dn", 0, 0, 0, 1, 0, 0, 0);
    chk("dn_final_count", 32'(count_out), 32'd8);

    // 3: saturate at top
    step("ld8", 0, 1, 8, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("sat", 0, 0, 0, 1, 1, 1, 0);
    chk("sat_hold", 32'(count_out), 32'd9);
    chk("sat_wrap_pulse", 32'(wrap_pulse), 32'd1);

    // 4: load priority over enable, and clamp of out-of-range load
    step("ld5_en", 0, 1, 5, 1, 1, 0, 0);
    chk("ld5_no_inc", 32'(count_out), 32'd5);
    step("ld13", 0, 1, 13, 1, 1, 0, 0);
    chk("ld13_clamp", 32'(count_out), 32'd9);

    // 5: set beats clear on the same edge, then clear alone
    step("clr_race", 0, 0, 0, 1, 1, 0, 1);
    chk("race_ovf_set", 32'(ovf_sticky), 32'd1);
    step("clr_alone", 0, 0, 0, 0, 1, 0, 1);
    chk("clr_ovf_zero", 32'(ovf_sticky), 32'd0);

    // 6: reset while counting, then hold with en low
    step("ld6", 0, 1, 6, 0, 1, 0, 0);
    step("mid_rst", 1, 0, 0, 1, 1, 0, 0);
    step("ld3", 0, 1, 3, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, 0, 1, 0, 0);
    chk("hold_count", 32'(count_out), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
